// File: rtl/acc_cmem_responder_if.sv
// Request-type package and the cmem request/response channel between the
// accelerator adapter (master) and the core-side responder (slave).
package acc_pkg;
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } mem_req_type_e;
endpackage

interface acc_cmem_responder_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
);
    logic                      cmem_q_valid;
    logic                      cmem_q_ready;
    acc_pkg::mem_req_type_e    cmem_q_req_type;
    logic [ADDR_WIDTH-1:0]     cmem_q_addr;
    logic [31:0]               cmem_q_wdata;
    logic [1:0]                cmem_q_size;
    logic                      cmem_q_unsigned;
    logic                      cmem_q_mode;
    logic                      cmem_q_spec;
    logic                      cmem_q_endoftransaction;
    logic [ID_WIDTH-1:0]       cmem_q_id;
    logic                      cmem_p_valid;
    logic                      cmem_p_ready;
    logic [31:0]               cmem_p_rdata;
    logic                      cmem_p_status;
    logic [ID_WIDTH-1:0]       cmem_p_id;

    modport master (
        output cmem_q_valid, cmem_q_req_type, cmem_q_addr, cmem_q_wdata, cmem_q_size,
               cmem_q_unsigned, cmem_q_mode, cmem_q_spec, cmem_q_endoftransaction,
               cmem_q_id, cmem_p_ready,
        input  cmem_q_ready, cmem_p_valid, cmem_p_rdata, cmem_p_status, cmem_p_id
    );

    modport slave (
        input  cmem_q_valid, cmem_q_req_type, cmem_q_addr, cmem_q_wdata, cmem_q_size,
               cmem_q_unsigned, cmem_q_mode, cmem_q_spec, cmem_q_endoftransaction,
               cmem_q_id, cmem_p_ready,
        output cmem_q_ready, cmem_p_valid, cmem_p_rdata, cmem_p_status, cmem_p_id
    );
endinterface

// File: rtl/acc_cmem_responder.sv
// Executes single-beat cmem load/store requests on the core OBI data port.
// Optional macro CMEM_MISALIGN_CHECK_EN rejects misaligned half/word accesses.
module acc_cmem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    acc_cmem_responder_if.slave   cmem,
    output logic                  data_req_o,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_o,
    output logic                  data_we_o,
    output logic [3:0]            data_be_o,
    output logic [31:0]           data_wdata_o,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           data_rdata_i,
    input  logic                  data_err_i,
    output logic                  busy_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] RSP  = 2'd3;

    logic [1:0]            state_q;
    logic                  we_q;
    logic                  unsigned_q;
    logic                  status_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;
    logic [1:0]            size_q;
    logic [ID_WIDTH-1:0]   id_q;

    logic        q_hs;
    logic        bad_req;
    logic        in_req;
    logic [1:0]  offset;
    logic [31:0] lane;
    logic [31:0] load_val;
    logic [3:0]  be;
    logic [31:0] wdata_rep;
    logic        unused_eot;

    assign unused_eot = cmem.cmem_q_endoftransaction;
    assign offset     = addr_q[1:0];
    assign q_hs       = cmem.cmem_q_valid && cmem.cmem_q_ready;
    assign in_req     = (state_q == REQ) && !rst_i;

    // Requests that complete without touching the bus with an error status.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        bad_req = cmem.cmem_q_spec || (cmem.cmem_q_size == 2'b11);
`ifdef CMEM_MISALIGN_CHECK_EN
        if ((cmem.cmem_q_size == 2'b01 && cmem.cmem_q_addr[0]) ||
            (cmem.cmem_q_size == 2'b10 && cmem.cmem_q_addr[1:0] != 2'b00)) begin
            bad_req = 1'b1;
        end
`endif
    end

    always_comb begin
        lane = data_rdata_i >> {offset, 3'b000};
        case (size_q)
            2'b00:   load_val = {{24{~unsigned_q & lane[7]}}, lane[7:0]};
            2'b01:   load_val = {{16{~unsigned_q & lane[15]}}, lane[15:0]};
            default: load_val = lane;
        endcase
    end

    always_comb begin
        case (size_q)
            2'b00: begin
                be        = 4'b0001 << offset;
                wdata_rep = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                be        = 4'b0011 << offset;
                wdata_rep = {2{wdata_q[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = wdata_q;
            end
        endcase
    end

    assign data_req_o   = in_req;
    assign data_addr_o  = in_req ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign data_we_o    = in_req && we_q;
    assign data_be_o    = in_req ? be : 4'b0000;
    assign data_wdata_o = in_req ? wdata_rep : 32'h0;

    assign cmem.cmem_q_ready  = (state_q == IDLE) && !rst_i;
    assign cmem.cmem_p_valid  = (state_q == RSP) && !rst_i;
    assign cmem.cmem_p_rdata  = rdata_q;
    assign cmem.cmem_p_status = status_q;
    assign cmem.cmem_p_id     = id_q;
    assign busy_o             = (state_q != IDLE) && !rst_i;

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            status_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            size_q     <= '0;
            id_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (q_hs) begin
                        we_q       <= (cmem.cmem_q_req_type == acc_pkg::WRITE);
                        addr_q     <= cmem.cmem_q_addr;
                        wdata_q    <= cmem.cmem_q_wdata;
                        size_q     <= cmem.cmem_q_size;
                        unsigned_q <= cmem.cmem_q_unsigned;
                        id_q       <= cmem.cmem_q_id;
                        rdata_q    <= '0;
                        status_q   <= 1'b0;
                        if (cmem.cmem_q_mode) begin
                            state_q <= RSP;
                        end else if (bad_req) begin
                            status_q <= 1'b1;
                            state_q  <= RSP;
                        end else begin
                            state_q <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (data_gnt_i) state_q <= WAIT;
                end
                WAIT: begin
                    if (data_rvalid_i) begin
                        state_q  <= RSP;
                        status_q <= data_err_i;
                        rdata_q  <= (data_err_i || we_q) ? 32'h0 : load_val;
                    end
                end
                RSP: begin
                    if (cmem.cmem_p_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_cmem_responder.sv
// Randomized bench for acc_cmem_responder: a transaction-level model predicts
// bus beats and responses; a negedge monitor compares every cycle.
module tb_acc_cmem_responder;
    localparam int AW = 32;
    localparam int IW = 4;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic        mode;
        logic        spec;
        logic [3:0]  id;
        logic [31:0] bus_rdata;
        logic        err;
        int          gnt_dly;
        int          rv_dly;
        int          prdy_dly;
    } txn_t;

    typedef struct {
        logic        bus;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        status;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        data_req_o;
    logic        data_gnt_i;
    logic [31:0] data_addr_o;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_wdata_o;
    logic        data_rvalid_i;
    logic [31:0] data_rdata_i;
    logic        data_err_i;
    logic        busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic       mon_en = 1'b0;
    logic       exp_qready, exp_req, exp_pvalid, exp_busy;
    exp_t       cur;
    logic [3:0] cur_id;

    always #5 clk_i = ~clk_i;

    acc_cmem_responder_if #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) cif ();

    acc_cmem_responder #(.ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .cmem          (cif),
        .data_req_o    (data_req_o),
        .data_gnt_i    (data_gnt_i),
        .data_addr_o   (data_addr_o),
        .data_we_o     (data_we_o),
        .data_be_o     (data_be_o),
        .data_wdata_o  (data_wdata_o),
        .data_rvalid_i (data_rvalid_i),
        .data_rdata_i  (data_rdata_i),
        .data_err_i    (data_err_i),
        .busy_o        (busy_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Transaction-level reference: byte-lane arithmetic straight from the rules.
    function automatic exp_t model(input txn_t t);
        exp_t            e;
        int              off;
        int              n;
        longint unsigned v;
        longint unsigned mask;
        off      = int'(t.addr[1:0]);
        n        = (t.size == 2'd0) ? 1 : (t.size == 2'd1) ? 2 : 4;
        e.bus    = 1'b0;
        e.we     = t.we;
        e.be     = 4'b0;
        e.wdata  = 32'h0;
        e.addr   = {t.addr[31:2], 2'b00};
        e.rdata  = 32'h0;
        e.status = 1'b0;
        if (t.mode) return e;
        if (t.spec || t.size == 2'd3) begin
            e.status = 1'b1;
            return e;
        end
`ifdef CMEM_MISALIGN_CHECK_EN
        if (off % n != 0) begin
            e.status = 1'b1;
            return e;
        end
`endif
        e.bus = 1'b1;
        if (n == 4) e.be = 4'hF;
        else for (int i = 0; i < 4; i++) if (i >= off && i < off + n) e.be[i] = 1'b1;
        if (t.size == 2'd0)      e.wdata = 32'(t.wdata[7:0]) * 32'h0101_0101;
        else if (t.size == 2'd1) e.wdata = 32'(t.wdata[15:0]) * 32'h0001_0001;
        else                     e.wdata = t.wdata;
        if (t.err) begin
            e.status = 1'b1;
        end else if (!t.we) begin
            v    = 64'(t.bus_rdata) >> (8 * off);
            mask = (64'd1 << (8 * n)) - 64'd1;
            v    = v & mask;
            if (!t.uns && n < 4 && v[8*n-1]) v = v | ~mask;
            e.rdata = v[31:0];
        end
        return e;
    endfunction

    always @(negedge clk_i) begin
        if (mon_en) begin
            check("q_ready", 32'(cif.cmem_q_ready), 32'(exp_qready));
            check("data_req", 32'(data_req_o), 32'(exp_req));
            check("p_valid", 32'(cif.cmem_p_valid), 32'(exp_pvalid));
            check("busy", 32'(busy_o), 32'(exp_busy));
            if (exp_req) begin
                check("data_addr", data_addr_o, cur.addr);
                check("data_we", 32'(data_we_o), 32'(cur.we));
                check("data_be", 32'(data_be_o), 32'(cur.be));
                check("data_wdata", data_wdata_o, cur.wdata);
            end
            if (exp_pvalid) begin
                check("p_rdata", cif.cmem_p_rdata, cur.rdata);
                check("p_status", 32'(cif.cmem_p_status), 32'(cur.status));
                check("p_id", 32'(cif.cmem_p_id), 32'(cur_id));
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic scramble_q();
        cif.cmem_q_addr     = $urandom;
        cif.cmem_q_wdata    = $urandom;
        cif.cmem_q_size     = 2'($urandom_range(3));
        cif.cmem_q_unsigned = 1'($urandom_range(1));
        cif.cmem_q_mode     = 1'($urandom_range(1));
        cif.cmem_q_spec     = 1'($urandom_range(1));
        cif.cmem_q_id       = 4'($urandom_range(15));
    endtask

    task automatic present(input txn_t t);
        cif.cmem_q_valid            = 1'b1;
        cif.cmem_q_req_type         = t.we ? acc_pkg::WRITE : acc_pkg::READ;
        cif.cmem_q_addr             = t.addr;
        cif.cmem_q_wdata            = t.wdata;
        cif.cmem_q_size             = t.size;
        cif.cmem_q_unsigned         = t.uns;
        cif.cmem_q_mode             = t.mode;
        cif.cmem_q_spec             = t.spec;
        cif.cmem_q_endoftransaction = 1'($urandom_range(1));
        cif.cmem_q_id               = t.id;
    endtask

    // Called at posedge+1 with the responder idle; returns at posedge+1 idle again.
    task automatic run_txn(input txn_t t);
        cur    = model(t);
        cur_id = t.id;
        present(t);
        exp_qready = 1'b1; exp_req = 1'b0; exp_pvalid = 1'b0; exp_busy = 1'b0;
        next_cycle();
        cif.cmem_q_valid = 1'b0;
        scramble_q();
        exp_qready = 1'b0;
        exp_busy   = 1'b1;
        if (cur.bus) begin
            exp_req = 1'b1;
            for (int i = 0; i < t.gnt_dly; i++) begin
                data_gnt_i    = 1'b0;
                data_rvalid_i = 1'($urandom_range(1));
                data_rdata_i  = $urandom;
                data_err_i    = 1'($urandom_range(1));
                next_cycle();
            end
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_gnt_i    = 1'b1;
            next_cycle();
            data_gnt_i = 1'b0;
            exp_req    = 1'b0;
            for (int i = 0; i < t.rv_dly; i++) next_cycle();
            data_rvalid_i = 1'b1;
            data_rdata_i  = t.bus_rdata;
            data_err_i    = t.err;
            next_cycle();
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
            data_rdata_i  = $urandom;
        end
        exp_pvalid = 1'b1;
        for (int i = 0; i < t.prdy_dly; i++) begin
            cif.cmem_p_ready = 1'b0;
            next_cycle();
        end
        cif.cmem_p_ready = 1'b1;
        next_cycle();
        cif.cmem_p_ready = 1'b0;
        exp_pvalid = 1'b0;
        exp_busy   = 1'b0;
        exp_qready = 1'b1;
    endtask

    function automatic txn_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [1:0] size, input logic uns, input logic [31:0] rd,
                                input logic err);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.size = size; t.uns = uns;
        t.mode = 1'b0; t.spec = 1'b0; t.id = 4'($urandom_range(15));
        t.bus_rdata = rd; t.err = err; t.gnt_dly = 0; t.rv_dly = 0; t.prdy_dly = 0;
        return t;
    endfunction

    initial begin
        txn_t t;
        exp_t e;
        rst_i = 1'b1;
        cif.cmem_q_valid = 1'b0;
        cif.cmem_q_req_type = acc_pkg::READ;
        cif.cmem_q_endoftransaction = 1'b0;
        cif.cmem_p_ready = 1'b0;
        scramble_q();
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = 32'h0; data_err_i = 1'b0;
        exp_qready = 1'b0; exp_req = 1'b0; exp_pvalid = 1'b0; exp_busy = 1'b0;

        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        check("rst q_ready", 32'(cif.cmem_q_ready), 32'h0);
        check("rst data_req", 32'(data_req_o), 32'h0);
        check("rst p_valid", 32'(cif.cmem_p_valid), 32'h0);
        check("rst p_rdata", cif.cmem_p_rdata, 32'h0);
        check("rst p_status", 32'(cif.cmem_p_status), 32'h0);
        check("rst p_id", 32'(cif.cmem_p_id), 32'h0);
        check("rst busy", 32'(busy_o), 32'h0);
        check("rst data_be", 32'(data_be_o), 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        exp_qready = 1'b1;
        mon_en = 1'b1;

        // Hand-computed values pinning the model.
        e = model(mk(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0));
        check("pin word rdata", e.rdata, 32'hDEADBEEF);
        check("pin word be", 32'(e.be), 32'hF);
        e = model(mk(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 32'h80112233, 1'b0));
        check("pin sbyte rdata", e.rdata, 32'hFFFFFF80);
        check("pin sbyte be", 32'(e.be), 32'h8);
        e = model(mk(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 32'h80112233, 1'b0));
        check("pin ubyte rdata", e.rdata, 32'h00000080);
        e = model(mk(1'b1, 32'h202, 32'h0000ABCD, 2'd1, 1'b0, 32'h0, 1'b0));
        check("pin half be", 32'(e.be), 32'hC);
        check("pin half wdata", e.wdata, 32'hABCDABCD);
        e = model(mk(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'h12345678, 1'b1));
        check("pin err status", 32'(e.status), 32'h1);
        check("pin err rdata", e.rdata, 32'h0);
        e = model(mk(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0));
`ifdef CMEM_MISALIGN_CHECK_EN
        check("pin misalign bus", 32'(e.bus), 32'h0);
        check("pin misalign status", 32'(e.status), 32'h1);
`else
        check("pin misalign bus", 32'(e.bus), 32'h1);
        check("pin misalign be", 32'(e.be), 32'hF);
`endif

        // Directed transactions from the test plan.
        run_txn(mk(1'b0, 32'h100, 32'h0, 2'd2, 1'b0, 32'hDEADBEEF, 1'b0));
        run_txn(mk(1'b0, 32'h103, 32'h0, 2'd0, 1'b0, 32'h80112233, 1'b0));
        run_txn(mk(1'b0, 32'h103, 32'h0, 2'd0, 1'b1, 32'h80112233, 1'b0));
        t = mk(1'b1, 32'h202, 32'h0000ABCD, 2'd1, 1'b0, 32'h0, 1'b0);
        t.gnt_dly = 3;
        run_txn(t);
        t = mk(1'b0, 32'h300, 32'h0, 2'd2, 1'b0, 32'hCAFEF00D, 1'b1);
        t.prdy_dly = 4;
        run_txn(t);
        t = mk(1'b0, 32'h400, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
        t.mode = 1'b1;
        run_txn(t);
        t = mk(1'b0, 32'h404, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
        t.spec = 1'b1;
        run_txn(t);
        run_txn(mk(1'b0, 32'h101, 32'h0, 2'd2, 1'b0, 32'h11223344, 1'b0));

        // Reset while waiting for the read response; the late rvalid must be ignored.
        t = mk(1'b0, 32'h500, 32'h0, 2'd2, 1'b0, 32'h0, 1'b0);
        cur = model(t);
        cur_id = t.id;
        present(t);
        next_cycle();
        cif.cmem_q_valid = 1'b0;
        exp_qready = 1'b0; exp_req = 1'b1; exp_busy = 1'b1;
        data_gnt_i = 1'b1;
        next_cycle();
        data_gnt_i = 1'b0;
        exp_req = 1'b0;
        next_cycle();
        rst_i = 1'b1;
        exp_busy = 1'b0;
        next_cycle();
        rst_i = 1'b0;
        data_rvalid_i = 1'b1;
        data_rdata_i = 32'h55AA55AA;
        exp_qready = 1'b1;
        next_cycle();
        data_rvalid_i = 1'b0;
        check("post-rst p_rdata", cif.cmem_p_rdata, 32'h0);
        check("post-rst p_status", 32'(cif.cmem_p_status), 32'h0);
        check("post-rst p_id", 32'(cif.cmem_p_id), 32'h0);
        run_txn(mk(1'b0, 32'h600, 32'h0, 2'd1, 1'b0, 32'h8001_7FFF, 1'b0));

        // Randomized traffic.
        for (int k = 0; k < 300; k++) begin
            t.we        = 1'($urandom_range(1));
            t.addr      = $urandom;
            t.wdata     = $urandom;
            t.size      = ($urandom_range(9) == 0) ? 2'd3 : 2'($urandom_range(2));
            t.uns       = 1'($urandom_range(1));
            t.mode      = ($urandom_range(7) == 0);
            t.spec      = ($urandom_range(7) == 0);
            t.id        = 4'($urandom_range(15));
            t.bus_rdata = $urandom;
            t.err       = ($urandom_range(7) == 0);
            t.gnt_dly   = int'($urandom_range(3));
            t.rv_dly    = int'($urandom_range(3));
            t.prdy_dly  = int'($urandom_range(3));
            run_txn(t);
            for (int g = 0; g < int'($urandom_range(2)); g++) next_cycle();
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/acc_cmem_responder.md
Name: acc_cmem_responder

Overview:
Core-side responder for the accelerator memory (cmem) request/response channel. Accepts single-beat load/store requests offloaded by the FPU subsystem and executes them on the core's OBI-style data port. Returns load data or store completion, with an error status, on the cmem response channel. Sits between the X-interface accelerator adapter and the LSU data-port arbiter.

Parameters:
ADDR_WIDTH, 32, width of request address and data_addr_o
ID_WIDTH, 4, width of request/response transaction id

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
cmem_q_valid_i  in  1  request valid
cmem_q_ready_o  out  1  request ready
cmem_q_req_type_i  in  acc_pkg::mem_req_type_e  READ or WRITE
cmem_q_addr_i  in  ADDR_WIDTH  byte address
cmem_q_wdata_i  in  32  store data, LSB-aligned
cmem_q_size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
cmem_q_unsigned_i  in  1  load zero-extend when 1
cmem_q_mode_i  in  1  1 = probe, no memory access
cmem_q_spec_i  in  1  speculative request (unsupported)
cmem_q_endoftransaction_i  in  1  single-beat marker, accepted either value
cmem_q_id_i  in  ID_WIDTH  transaction id
cmem_p_valid_o  out  1  response valid
cmem_p_ready_i  in  1  response ready
cmem_p_rdata_o  out  32  load result, 0 for stores/errors/probes
cmem_p_status_o  out  1  1 = error
cmem_p_id_o  out  ID_WIDTH  echoed id
data_req_o  out  1  OBI request
data_gnt_i  in  1  OBI grant
data_addr_o  out  ADDR_WIDTH  word-aligned address
data_we_o  out  1  write enable
data_be_o  out  4  byte enables
data_wdata_o  out  32  lane-replicated store data
data_rvalid_i  in  1  OBI response valid
data_rdata_i  in  32  OBI read data
data_err_i  in  1  OBI bus error
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i high at clk edge): state IDLE; all outputs 0 (incl. cmem_q_ready_o, data_req_o, cmem_p_valid_o, rdata, status, id). Reset mid-transaction discards it; later data_rvalid_i ignored.
- FSM IDLE/REQ/WAIT/RSP. One transaction in flight; no request pipelining.
- IDLE: cmem_q_ready_o=1. On handshake: latch type, addr, wdata, size, unsigned, id. Next state:
  - mode=1 -> RSP, status 0, rdata 0, no bus access.
  - spec=1 or size=11 -> RSP, status 1, no bus access.
  - else -> REQ.
- REQ: data_req_o=1; addr/we/be/wdata stable until data_gnt_i; on gnt -> WAIT. rvalid seen in REQ is ignored.
- WAIT: on data_rvalid_i -> RSP.
  - err=1: status 1, rdata 0.
  - load: extract lane at addr[1:0], sign- or zero-extend per unsigned.
  - store: rdata 0, status 0.
- RSP: cmem_p_valid_o=1; rdata/status/id held stable until cmem_p_ready_i; on handshake -> IDLE.
- cmem_q_ready_o=0 outside IDLE, including the RSP handshake cycle; next accept is at least one cycle after the response handshake.
- Byte enables: byte -> 0001<<addr[1:0]; half -> 0011<<addr[1:0]; word -> 1111.
- Store data: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word as is.
- data_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
- Latency: accept at cycle 0; data_req_o at cycle 1; gnt at 1 and rvalid at 2 give cmem_p_valid_o at cycle 3 (minimum).
- cmem_q_endoftransaction_i has no effect.

Optional Feature:
CMEM_MISALIGN_CHECK_EN
- Defined: half with addr[0]=1 or word with addr[1:0]!=0 goes IDLE -> RSP with status 1, no bus access.
- Undefined: no check; addr[1:0] is used as the lane offset as-is. The be shift truncates to 4 bits and the access is issued.

Test Plan:
- Word load addr 0x100, gnt at cycle 1, rvalid at cycle 2 with rdata 0xDEADBEEF -> data_be_o=1111, p_valid at cycle 3, rdata 0xDEADBEEF, status 0, id echoed.
- Byte load addr 0x103, unsigned=0, rdata 0x80112233 -> be=1000, rdata 0xFFFFFF80. Same with unsigned=1 -> 0x00000080.
- Half store addr 0x202, wdata 0x0000ABCD, gnt delayed 3 cycles -> data_req_o held 3 cycles with be=1100, we=1, wdata 0xABCDABCD; then response rdata 0, status 0.
- Load with data_err_i=1 on rvalid, cmem_p_ready_i low 4 cycles -> p_valid held with status 1, rdata 0, stable; cmem_q_ready_o stays 0.
- Probe (mode=1) and spec=1 requests -> data_req_o never asserted. Probe responds status 0; spec responds status 1. Word at addr 0x101 with CMEM_MISALIGN_CHECK_EN -> status 1, no bus access.
- rst_i asserted in WAIT, then rvalid arrives -> outputs 0, no cmem_p_valid_o, next request accepted normally.
